// File: rtl/tour_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tour_pkg
// Purpose  : Shared opcodes, heading codes, response bytes and FSM state type
//            for the knight's-tour command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tour_pkg;

   // Command opcodes placed in cmd[15:12]
   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_FANFARE = 4'h3;

   // Heading codes placed in cmd[11:4]
   localparam logic [7:0] HDG_NORTH  = 8'h00;
   localparam logic [7:0] HDG_WEST   = 8'h3F;
   localparam logic [7:0] HDG_SOUTH  = 8'h7F;
   localparam logic [7:0] HDG_EAST   = 8'hBF;

   // Response bytes toward the UART wrapper
   localparam logic [7:0] RESP_DONE  = 8'hA5;
   localparam logic [7:0] RESP_POS   = 8'h5A;

   // Index of the final move of a 24-move tour
   localparam logic [4:0] LAST_MOVE  = 5'd23;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VERT   = 3'd1,
      HOLD_V = 3'd2,
      HORZ   = 3'd3,
      HOLD_H = 3'd4
   } state_e;

endpackage : tour_pkg
`default_nettype wire

// File: rtl/tour_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : tour_cmd_if
// Purpose  : Bundle of command/response signals around the tour sequencer.
//            slave = the sequencer itself, master = its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface tour_cmd_if;

   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy_UART;
   logic [7:0]  resp;

   modport slave (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, cmd, cmd_rdy, clr_cmd_rdy_UART, resp
   );

   modport master (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, cmd, cmd_rdy, clr_cmd_rdy_UART, resp
   );

endinterface : tour_cmd_if
`default_nettype wire

// File: rtl/tour_cmd_move_decode.sv
`default_nettype none
// ============================================================================
// Module   : move_decode
// Purpose  : Splits a one-hot knight move into a vertical leg and a
//            horizontal leg (heading code + square count each).
// Revision : 1.0 - initial release
// ============================================================================
module move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] heading_v,
   output logic [3:0] sq_v,
   output logic [7:0] heading_h,
   output logic [3:0] sq_h
);

   // Table lookup of (dx,dy); anything not one-hot falls back to bit0 (+1,+2)
   always_comb begin
      heading_v = HDG_NORTH;
      sq_v      = 4'd2;
      heading_h = HDG_EAST;
      sq_h      = 4'd1;
      case (move)
         8'h02: begin heading_v = HDG_NORTH; sq_v = 4'd2; heading_h = HDG_WEST; sq_h = 4'd1; end
         8'h04: begin heading_v = HDG_NORTH; sq_v = 4'd1; heading_h = HDG_WEST; sq_h = 4'd2; end
         8'h08: begin heading_v = HDG_SOUTH; sq_v = 4'd1; heading_h = HDG_WEST; sq_h = 4'd2; end
         8'h10: begin heading_v = HDG_SOUTH; sq_v = 4'd2; heading_h = HDG_WEST; sq_h = 4'd1; end
         8'h20: begin heading_v = HDG_SOUTH; sq_v = 4'd2; heading_h = HDG_EAST; sq_h = 4'd1; end
         8'h40: begin heading_v = HDG_SOUTH; sq_v = 4'd1; heading_h = HDG_EAST; sq_h = 4'd2; end
         8'h80: begin heading_v = HDG_NORTH; sq_v = 4'd1; heading_h = HDG_EAST; sq_h = 4'd2; end
         default: ;
      endcase
   end

endmodule : move_decode
`default_nettype wire

// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tour_cmd
// Purpose  : Multiplexes UART commands with autonomous knight's-tour playback.
//            Each tour move becomes a vertical "move" command followed by a
//            horizontal "move with fanfare" command.
// Revision : 1.0 - initial release
// ============================================================================
module tour_cmd
   import tour_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   tour_cmd_if.slave  bus
);

   state_e      state, state_nxt;
   logic        tour_mode;
   logic [4:0]  mv_indx_q;
   logic [15:0] cmd_q;
   logic        cmd_rdy_q;

   logic        launch, finish, advance, load_v, load_h;
   logic [7:0]  heading_v, heading_h;
   logic [3:0]  sq_v, sq_h;

   move_decode u_move_decode (
      .move      (bus.move),
      .heading_v (heading_v),
      .sq_v      (sq_v),
      .heading_h (heading_h),
      .sq_h      (sq_h)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and per-state datapath controls
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      finish    = 1'b0;
      advance   = 1'b0;
      load_v    = 1'b0;
      load_h    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_tour) begin
               state_nxt = VERT;
               launch    = 1'b1;
            end
         end
         VERT: begin
            load_v = 1'b1;
            // clr wins over a coincident send_resp: only one step per cycle
            if (bus.clr_cmd_rdy) state_nxt = HOLD_V;
         end
         HOLD_V: begin
            if (bus.send_resp) state_nxt = HORZ;
         end
         HORZ: begin
            load_h = 1'b1;
            if (bus.clr_cmd_rdy) state_nxt = HOLD_H;
         end
         HOLD_H: begin
            if (bus.send_resp) begin
               if (mv_indx_q == LAST_MOVE) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = VERT;
                  advance   = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Tour flag, move index and the registered command toward cmd_proc
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tour_mode <= 1'b0;
         mv_indx_q <= '0;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
      end else begin
         if (launch) begin
            tour_mode <= 1'b1;
            mv_indx_q <= '0;
         end else if (finish) begin
            tour_mode <= 1'b0;
         end else if (advance) begin
            mv_indx_q <= mv_indx_q + 5'd1;
         end

         // Command is rebuilt every leg cycle so it follows the move memory;
         // ready drops the cycle after the consumer acknowledges it.
         if (load_v) begin
            cmd_q     <= {OP_MOVE, heading_v, sq_v};
            cmd_rdy_q <= ~bus.clr_cmd_rdy;
         end else if (load_h) begin
            cmd_q     <= {OP_FANFARE, heading_h, sq_h};
            cmd_rdy_q <= ~bus.clr_cmd_rdy;
         end else begin
            cmd_rdy_q <= 1'b0;
         end
      end
   end

   assign bus.mv_indx          = mv_indx_q;
   assign bus.cmd              = tour_mode ? cmd_q     : bus.cmd_UART;
   assign bus.cmd_rdy          = tour_mode ? cmd_rdy_q : bus.cmd_rdy_UART;
   assign bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy & ~tour_mode;
   assign bus.resp             = (tour_mode && !((state == HOLD_H) && (mv_indx_q == LAST_MOVE)))
                                 ? RESP_POS : RESP_DONE;

endmodule : tour_cmd
`default_nettype wire

// File: tb/tb_tour_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_tour_cmd
// Purpose  : Self-checking bench for tour_cmd with a (dx,dy)-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tour_cmd;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   tour_cmd_if bus ();

   tour_cmd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Solution memory, read asynchronously at the DUT's move index
   logic [7:0] moves [24];
   assign bus.move = (bus.mv_indx < 5'd24) ? moves[bus.mv_indx] : 8'h00;

   // Reference: knight offsets by bit, legs derived from the sign/magnitude
   function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit horiz);
      int dx [8];
      int dy [8];
      int k;
      int d;
      logic [7:0] hd;
      logic [3:0] sq;
      dx = '{1, -1, -2, -2, -1, 1, 2, 2};
      dy = '{2, 2, 1, -1, -2, -2, -1, 1};
      k  = 0;
      if ($countones(mv) == 1)
         for (int i = 0; i < 8; i++) if (mv[i]) k = i;
      d  = horiz ? dx[k] : dy[k];
      sq = 4'((d < 0) ? -d : d);
      if (horiz) hd = (d > 0) ? 8'hBF : 8'h3F;
      else       hd = (d > 0) ? 8'h00 : 8'h7F;
      return {(horiz ? 4'h3 : 4'h2), hd, sq};
   endfunction

   function automatic logic [7:0] rand_move();
      logic [7:0] m;
      if ($urandom_range(0, 3) == 0) begin
         m = 8'($urandom);
      end else begin
         m = 8'h01;
         m = m << $urandom_range(0, 7);
      end
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start_tour   = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;
      bus.cmd_rdy_UART = 1'b0;
      bus.cmd_UART     = 16'h0000;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic pulse_start();
      bus.start_tour = 1'b1; step(); bus.start_tour = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.clr_cmd_rdy = 1'b1; step(); bus.clr_cmd_rdy = 1'b0;
   endtask

   task automatic pulse_send();
      bus.send_resp = 1'b1; step(); bus.send_resp = 1'b0;
   endtask

   // Bounded wait for cmd_rdy; reports whether it appeared
   task automatic wait_rdy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (bus.cmd_rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Plays one full move, returning what the DUT produced
   task automatic play_move(output bit ok, output logic [15:0] v,
                            output logic [15:0] h, output logic [7:0] r);
      bit a, b;
      wait_rdy(a);
      v = bus.cmd;
      pulse_clr();
      pulse_send();
      wait_rdy(b);
      h = bus.cmd;
      pulse_clr();
      r = bus.resp;
      pulse_send();
      ok = a & b;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n            = 1'b0;
      bus.cmd_UART     = 16'hC3A7;
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy  = 1'b1;
      step();
      n_tests++; if (bus.mv_indx !== 5'd0) begin n_fail++; $display("FAIL reset_mv_indx got=%0d exp=0", bus.mv_indx); end
      n_tests++; if (bus.cmd !== 16'hC3A7) begin n_fail++; $display("FAIL reset_cmd got=%h exp=c3a7", bus.cmd); end
      n_tests++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
      n_tests++; if (bus.clr_cmd_rdy_UART !== 1'b1) begin n_fail++; $display("FAIL reset_clr_uart got=%b exp=1", bus.clr_cmd_rdy_UART); end
      n_tests++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL reset_resp got=%h exp=a5", bus.resp); end
      bus.clr_cmd_rdy = 1'b0;
      #1;
      n_tests++; if (bus.clr_cmd_rdy_UART !== 1'b0) begin n_fail++; $display("FAIL reset_clr_uart_low got=%b exp=0", bus.clr_cmd_rdy_UART); end
      rst_n = 1'b1;
      step();
      idle_inputs();
   endtask

   task automatic test_passthrough();
      logic [15:0] c;
      logic r, k;
      bus.cmd_UART = 16'h3001; bus.cmd_rdy_UART = 1'b1;
      step();
      n_tests++; if (bus.cmd !== 16'h3001) begin n_fail++; $display("FAIL pass_cmd got=%h exp=3001", bus.cmd); end
      n_tests++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL pass_rdy got=%b exp=1", bus.cmd_rdy); end
      n_tests++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL pass_resp got=%h exp=a5", bus.resp); end
      for (int i = 0; i < 6; i++) begin
         c = 16'($urandom); r = 1'($urandom); k = 1'($urandom);
         bus.cmd_UART = c; bus.cmd_rdy_UART = r; bus.clr_cmd_rdy = k;
         #1;
         n_tests++; if (bus.cmd !== c) begin n_fail++; $display("FAIL pass_rand_cmd got=%h exp=%h", bus.cmd, c); end
         n_tests++; if (bus.cmd_rdy !== r) begin n_fail++; $display("FAIL pass_rand_rdy got=%b exp=%b", bus.cmd_rdy, r); end
         n_tests++; if (bus.clr_cmd_rdy_UART !== k) begin n_fail++; $display("FAIL pass_rand_clr got=%b exp=%b", bus.clr_cmd_rdy_UART, k); end
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_single_move();
      bit ok;
      moves[0] = 8'h01;
      pulse_start();
      bus.cmd_rdy_UART = 1'b1;
      #1;
      n_tests++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL single_uart_ignored got=%b exp=0", bus.cmd_rdy); end
      wait_rdy(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_vert_timeout got=0 exp=1"); end
      n_tests++; if (bus.cmd !== 16'h2002) begin n_fail++; $display("FAIL single_vert_cmd got=%h exp=2002", bus.cmd); end
      bus.clr_cmd_rdy = 1'b1;
      #1;
      n_tests++; if (bus.clr_cmd_rdy_UART !== 1'b0) begin n_fail++; $display("FAIL single_clr_gated got=%b exp=0", bus.clr_cmd_rdy_UART); end
      step();
      bus.clr_cmd_rdy = 1'b0;
      n_tests++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy_drop got=%b exp=0", bus.cmd_rdy); end
      pulse_send();
      wait_rdy(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_horz_timeout got=0 exp=1"); end
      n_tests++; if (bus.cmd !== 16'h3BF1) begin n_fail++; $display("FAIL single_horz_cmd got=%h exp=3bf1", bus.cmd); end
      apply_reset();
   endtask

   task automatic test_move_08();
      bit ok;
      logic [15:0] v, h;
      logic [7:0] r;
      moves[0] = 8'h08;
      pulse_start();
      play_move(ok, v, h, r);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL m08_timeout got=0 exp=1"); end
      n_tests++; if (v !== 16'h27F1) begin n_fail++; $display("FAIL m08_vert got=%h exp=27f1", v); end
      n_tests++; if (h !== 16'h33F2) begin n_fail++; $display("FAIL m08_horz got=%h exp=33f2", h); end
      n_tests++; if (r !== 8'h5A) begin n_fail++; $display("FAIL m08_resp got=%h exp=5a", r); end
      apply_reset();
   endtask

   task automatic test_full_tour();
      bit ok;
      logic [15:0] v, h, c;
      logic [7:0] r, er;
      for (int i = 0; i < 24; i++) moves[i] = rand_move();
      pulse_start();
      for (int i = 0; i < 24; i++) begin
         n_tests++; if (bus.mv_indx !== 5'(i)) begin n_fail++; $display("FAIL tour_idx got=%0d exp=%0d", bus.mv_indx, i); end
         play_move(ok, v, h, r);
         er = (i == 23) ? 8'hA5 : 8'h5A;
         n_tests++; if (!ok) begin n_fail++; $display("FAIL tour_timeout move=%0d got=0 exp=1", i); end
         n_tests++; if (v !== exp_cmd(moves[i], 1'b0)) begin n_fail++; $display("FAIL tour_vert move=%0d mv=%h got=%h exp=%h", i, moves[i], v, exp_cmd(moves[i], 1'b0)); end
         n_tests++; if (h !== exp_cmd(moves[i], 1'b1)) begin n_fail++; $display("FAIL tour_horz move=%0d mv=%h got=%h exp=%h", i, moves[i], h, exp_cmd(moves[i], 1'b1)); end
         n_tests++; if (r !== er) begin n_fail++; $display("FAIL tour_resp move=%0d got=%h exp=%h", i, r, er); end
      end
      c = 16'($urandom);
      bus.cmd_UART = c;
      step();
      step();
      n_tests++; if (bus.mv_indx !== 5'd23) begin n_fail++; $display("FAIL tour_end_idx got=%0d exp=23", bus.mv_indx); end
      n_tests++; if (bus.cmd !== c) begin n_fail++; $display("FAIL tour_end_cmd got=%h exp=%h", bus.cmd, c); end
      n_tests++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL tour_end_rdy got=%b exp=0", bus.cmd_rdy); end
      n_tests++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL tour_end_resp got=%h exp=a5", bus.resp); end
      apply_reset();
   endtask

   task automatic test_reset_mid_tour();
      bit ok;
      logic [15:0] v, h, c;
      logic [7:0] r;
      for (int i = 0; i < 24; i++) moves[i] = rand_move();
      pulse_start();
      for (int i = 0; i < 7; i++) play_move(ok, v, h, r);
      wait_rdy(ok);
      pulse_clr();
      n_tests++; if (bus.mv_indx !== 5'd7) begin n_fail++; $display("FAIL mid_idx got=%0d exp=7", bus.mv_indx); end
      c = 16'($urandom);
      bus.cmd_UART = c;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.mv_indx !== 5'd0) begin n_fail++; $display("FAIL mid_rst_idx got=%0d exp=0", bus.mv_indx); end
      n_tests++; if (bus.cmd !== c) begin n_fail++; $display("FAIL mid_rst_cmd got=%h exp=%h", bus.cmd, c); end
      n_tests++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL mid_rst_resp got=%h exp=a5", bus.resp); end
      step();
      rst_n = 1'b1;
      pulse_send();
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++; if (bus.cmd_rdy !== 1'b0 || bus.cmd !== c) begin n_fail++; $display("FAIL mid_no_resume rdy=%b cmd=%h exp rdy=0 cmd=%h", bus.cmd_rdy, bus.cmd, c); end
      end
      pulse_start();
      wait_rdy(ok);
      n_tests++; if (!ok || bus.cmd !== exp_cmd(moves[0], 1'b0)) begin n_fail++; $display("FAIL mid_restart got=%h exp=%h", bus.cmd, exp_cmd(moves[0], 1'b0)); end
      apply_reset();
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [15:0] eh;
      moves[0] = rand_move();
      eh = exp_cmd(moves[0], 1'b1);
      pulse_start();
      wait_rdy(ok);
      bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_v cycle=%0d got=%b exp=0", i, bus.cmd_rdy); end
         step();
      end
      pulse_send();
      wait_rdy(ok);
      n_tests++; if (!ok || bus.cmd !== eh) begin n_fail++; $display("FAIL b2b_horz got=%h exp=%h", bus.cmd, eh); end
      pulse_start();
      pulse_send();
      step();
      n_tests++; if (bus.mv_indx !== 5'd0 || bus.cmd !== eh || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ignored idx=%0d cmd=%h rdy=%b exp idx=0 cmd=%h rdy=1", bus.mv_indx, bus.cmd, bus.cmd_rdy, eh); end
      pulse_clr();
      n_tests++; if (bus.resp !== 8'h5A) begin n_fail++; $display("FAIL b2b_resp got=%h exp=5a", bus.resp); end
      apply_reset();
   endtask

   initial begin
      for (int i = 0; i < 24; i++) moves[i] = 8'h01;
      idle_inputs();
      test_reset();
      test_passthrough();
      test_single_move();
      test_move_08();
      test_full_tour();
      test_reset_mid_tour();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

endmodule : tb_tour_cmd
`default_nettype wire
